// File: rtl/data_mem_ctrl.sv
// Single-port data memory controller: one request per cycle when idle, registered
// read data with a one-cycle valid pulse, and a word-per-cycle clear sequence.
module data_mem_ctrl #(
  parameter int DW             = 8,
  parameter int AW             = 8,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic          CLK,
  input  logic          Reset_n,
  input  logic          Req,
  input  logic          WriteMem,
  input  logic [AW-1:0] DataAddress,
  input  logic [DW-1:0] DataIn,
  input  logic          Clear,
  output logic          Ready,
  output logic [DW-1:0] DataOut,
  output logic          ReadValid,
  output logic          Busy
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] LAST_ADDR = (AW+1)'(DEPTH - 1);

  typedef enum logic {
    S_CLEARING = 1'b0,
    S_IDLE     = 1'b1
  } state_t;

  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? S_CLEARING : S_IDLE;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW:0]   r_clr_cnt;
  logic [AW:0]   w_clr_cnt_nxt;
  logic          w_rd_accept;
  logic          w_wr_accept;
  logic          w_mem_we;
  logic [AW-1:0] w_mem_addr;
  logic [DW-1:0] w_mem_wdata;
  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_data_out;
  logic          r_read_valid;

  assign Ready     = (r_state == S_IDLE) && !Clear;
  assign Busy      = (r_state == S_CLEARING);
  assign DataOut   = r_data_out;
  assign ReadValid = r_read_valid;

  // Request qualification
  always_comb begin
    w_rd_accept = 1'b0;
    w_wr_accept = 1'b0;
    if (Req && Ready) begin
      w_rd_accept = !WriteMem;
      w_wr_accept = WriteMem;
    end else begin
      w_rd_accept = 1'b0;
      w_wr_accept = 1'b0;
    end
  end

  // Next-state and clear-counter logic
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    case (r_state)
      S_IDLE: begin
        if (Clear) begin
          w_state_nxt   = S_CLEARING;
          w_clr_cnt_nxt = {(AW+1){1'b0}};
        end else begin
          w_state_nxt   = S_IDLE;
        end
      end
      S_CLEARING: begin
        // Finish on the last word explicitly instead of letting the counter wrap.
        if (r_clr_cnt == LAST_ADDR) begin
          w_state_nxt   = S_IDLE;
          w_clr_cnt_nxt = {(AW+1){1'b0}};
        end else begin
          w_state_nxt   = S_CLEARING;
          w_clr_cnt_nxt = r_clr_cnt + {{AW{1'b0}}, 1'b1};
        end
      end
      default: begin
        w_state_nxt   = RESET_STATE;
        w_clr_cnt_nxt = {(AW+1){1'b0}};
      end
    endcase
  end

  // Memory write-port mux: the clear sequence owns the port while active
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = DataAddress;
    w_mem_wdata = DataIn;
    if (r_state == S_CLEARING) begin
      w_mem_we    = Reset_n;
      w_mem_addr  = r_clr_cnt[AW-1:0];
      w_mem_wdata = {DW{1'b0}};
    end else begin
      w_mem_we    = w_wr_accept && Reset_n;
      w_mem_addr  = DataAddress;
      w_mem_wdata = DataIn;
    end
  end

  // State and clear-counter registers
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state   <= RESET_STATE;
      r_clr_cnt <= {(AW+1){1'b0}};
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  // Storage array; deliberately not reset, only the clear sequence zeroes it
  always_ff @(posedge CLK) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  // Registered read data and its one-cycle valid pulse
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_data_out   <= {DW{1'b0}};
      r_read_valid <= 1'b0;
    end else begin
      r_read_valid <= w_rd_accept;
      if (w_rd_accept) begin
        r_data_out <= r_mem[DataAddress];
      end
    end
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter DW, default 8, data word width in bits.
REQ-002 SHALL have parameter AW, default 8, address width; depth = 2^AW words.
REQ-003 SHALL have parameter CLEAR_ON_RESET, default 1, 1 = zero the whole array after reset release.
REQ-004 SHALL have port CLK  input  1  single clock; all state on posedge.
REQ-005 SHALL have port Reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port Req  input  1  access request, qualified by Ready.
REQ-007 SHALL have port WriteMem  input  1  1 = write, 0 = read; sampled with Req.
REQ-008 SHALL have port DataAddress  input  AW  word address.
REQ-009 SHALL have port DataIn  input  DW  write data.
REQ-010 SHALL have port Clear  input  1  software request to zero the array.
REQ-011 SHALL have port Ready  output  1  controller accepts a request this cycle.
REQ-012 SHALL have port DataOut  output  DW  registered read data; never high-Z.
REQ-013 SHALL have port ReadValid  output  1  one-cycle pulse, DataOut updated.
REQ-014 SHALL have port Busy  output  1  clear sequence in progress.

Function
REQ-015 SHALL implement a two-state FSM: CLEARING, IDLE.
REQ-016 SHALL drive Ready = (state == IDLE) && !Clear, combinationally.
REQ-017 SHALL accept a request on a posedge where Req && Ready; requests with Ready=0 are ignored, not queued; requester holds Req.
REQ-018 Accepted write SHALL store DataIn at DataAddress on the accepting edge.
REQ-019 Accepted read SHALL load array[DataAddress] into DataOut on the accepting edge; ReadValid = 1 for exactly the following cycle.
REQ-020 DataOut SHALL hold its last read value until the next accepted read; writes never change DataOut.
REQ-021 Write at cycle N followed by read of the same address at N+1 SHALL return the written data.
REQ-022 Back-to-back reads SHALL be accepted every cycle (throughput 1 per cycle, latency 1).
REQ-023 In IDLE, Clear = 1 on a posedge SHALL enter CLEARING with clear counter = 0; a coincident Req SHALL be ignored (Clear has priority).
REQ-024 In CLEARING, one word per cycle SHALL be written with 0 at address counter, counter incrementing by 1.
REQ-025 When the word at address 2^AW-1 is written, FSM SHALL return to IDLE on that edge; clear duration = exactly 2^AW cycles.
REQ-026 Busy SHALL equal (state == CLEARING); Ready = 0 throughout CLEARING.
REQ-027 Clear asserted while CLEARING SHALL be ignored (no restart).
REQ-028 Counter SHALL be AW+1 bits or compare against 2^AW-1 explicitly; it SHALL NOT wrap silently to 0 and continue.
REQ-029 ReadValid SHALL be 0 in every cycle not immediately following an accepted read.

Reset
REQ-030 On Reset_n = 0, asynchronously: DataOut = 0, ReadValid = 0, counter = 0.
REQ-031 On Reset_n = 0, state SHALL be CLEARING if CLEAR_ON_RESET = 1, else IDLE; Busy/Ready follow immediately.
REQ-032 Array contents SHALL NOT be reset by Reset_n; only the clear sequence zeroes them.
REQ-033 Reset asserted mid-clear SHALL abort the sequence; on release the clear restarts from address 0 (CLEAR_ON_RESET = 1).
REQ-034 Request accepted on the edge where reset asserts SHALL have no effect; no ReadValid after release.

Verification
REQ-035 Defaults, release reset -> Busy = 1, Ready = 0 for 256 cycles, then Ready = 1; read of any address 0x00..0xFF returns 0x00.
REQ-036 Write 0xA5 to 0x3C, next cycle read 0x3C -> cycle after: DataOut = 0xA5, ReadValid = 1 for one cycle only.
REQ-037 Write 0x11 to 0x00 and 0x22 to 0xFF, then back-to-back reads of 0xFF, 0x00 -> DataOut 0x22 then 0x11 on consecutive cycles, ReadValid high both.
REQ-038 Write 0x7E to 0x10, pulse Clear with Req read 0x10 same cycle -> read ignored, Busy for 256 cycles, Clear re-pulsed at cycle 100 ignored; later read 0x10 returns 0x00.
REQ-039 Assert Reset_n = 0 at clear count 50, release -> DataOut = 0, ReadValid = 0, clear restarts at 0 and lasts a full 256 cycles.
REQ-040 CLEAR_ON_RESET = 0, AW = 4, DW = 16: release reset -> Ready = 1 immediately; write 0xBEEF to 0xF, read 0xF -> DataOut = 0xBEEF.
